// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller in front of CP0.
// Holds the FSM state encoding and the cfg_sel register codes.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IrqIdle    = 2'd0,
    IrqReq     = 2'd1,
    IrqService = 2'd2
  } irq_state_e;

  localparam logic CFG_SEL_MASK = 1'b0;
  localparam logic CFG_SEL_MODE = 1'b1;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser per line plus a rising-edge detector on the synced value.
// All flops clear on asynchronous active-low reset.
module irq_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: latches, masks and prioritises N lines and
// raises a single non-nesting request toward CP0 until ERET.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [N_SRC-1:0] cfg_wdata,
  input  logic             glb_en,
  input  logic             ir_ack,
  input  logic             eret,
  output logic             ir_req,
  output logic [ID_W-1:0]  ir_id,
  output logic [N_SRC-1:0] pending,
  output logic             in_service
);

  // Lowest set index wins.
  function automatic logic [ID_W-1:0] prio_enc(input logic [N_SRC-1:0] vec);
    logic [ID_W-1:0] res;
    res = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (vec[i]) res = ID_W'(i);
    end
    return res;
  endfunction

  logic [N_SRC-1:0] sync_level;
  logic [N_SRC-1:0] sync_rise;

  irq_sync #(
    .WIDTH(N_SRC)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (irq_src),
    .level(sync_level),
    .rise (sync_rise)
  );

  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] mode_to_edge;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  id_d;
  logic             ack_hit;
  irq_state_e       state_q;
  irq_state_e       state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      mode_q <= '1;
    end else if (cfg_we) begin
      if (cfg_sel == CFG_SEL_MASK) mask_q <= cfg_wdata;
      else                         mode_q <= cfg_wdata;
    end
  end

  assign ack_hit = (state_q == IrqReq) && ir_ack;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      ack_clr[i] = ack_hit && (id_q == ID_W'(i));
    end
  end

  // Switching a line from level to edge drops its stale level-derived pending bit.
  assign mode_to_edge = (cfg_we && (cfg_sel == CFG_SEL_MODE)) ? (cfg_wdata & ~mode_q) : '0;

  assign pending_d = ((mode_q & (sync_rise | (pending_q & ~ack_clr))) | (~mode_q & sync_level))
                     & ~mode_to_edge;

  assign eligible = pending_q & mask_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IrqIdle: begin
        if (glb_en && (|eligible)) begin
          state_d = IrqReq;
          id_d    = prio_enc(eligible);
        end
      end
      IrqReq: begin
        if (ir_ack)       state_d = IrqService;
        else if (!glb_en) state_d = IrqIdle;
      end
      IrqService: begin
        if (eret) state_d = IrqIdle;
      end
      default: state_d = IrqIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IrqIdle;
      id_q      <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pending_q <= pending_d;
    end
  end

  assign ir_req     = (state_q == IrqReq);
  assign in_service = (state_q == IrqService);
  assign ir_id      = id_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the controller rules.
module tb_irq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq_src;
  logic         cfg_we;
  logic         cfg_sel;
  logic [N-1:0] cfg_wdata;
  logic         glb_en;
  logic         ir_ack;
  logic         eret;
  logic         ir_req;
  logic [2:0]   ir_id;
  logic [N-1:0] pending;
  logic         in_service;

  int n_checks = 0;
  int n_errors = 0;

  // Model: line history (sampled 1, 2, 3 edges ago), config, pending, phase.
  bit [N-1:0] m_h1, m_h2, m_h3, m_mask, m_mode, m_pend;
  int         m_phase;  // 0 idle, 1 requesting, 2 in service
  int         m_id;

  always #5 clk = ~clk;

  irq_ctrl #(
    .N_SRC(N),
    .ID_W (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .glb_en    (glb_en),
    .ir_ack    (ir_ack),
    .eret      (eret),
    .ir_req    (ir_req),
    .ir_id     (ir_id),
    .pending   (pending),
    .in_service(in_service)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_h3 = '0;
    m_mask = '0; m_mode = '1; m_pend = '0;
    m_phase = 0; m_id = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit [N-1:0] rise, clr, pn, elig;
    int win;
    rise = m_h2 & ~m_h3;
    clr  = '0;
    if (m_phase == 1 && ir_ack) clr[m_id] = 1'b1;
    for (int i = 0; i < N; i++)
      pn[i] = m_mode[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : m_h2[i];
    if (cfg_we && cfg_sel) pn = pn & ~(cfg_wdata & ~m_mode);
    elig = m_pend & m_mask;
    win = -1;
    for (int i = 0; i < N; i++) if (elig[i] && win < 0) win = i;
    case (m_phase)
      0: if (glb_en && win >= 0) begin m_phase = 1; m_id = win; end
      1: if (ir_ack) m_phase = 2; else if (!glb_en) m_phase = 0;
      default: if (eret) m_phase = 0;
    endcase
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = irq_src;
    if (cfg_we) begin
      if (cfg_sel) m_mode = cfg_wdata;
      else         m_mask = cfg_wdata;
    end
    m_pend = pn;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".ir_req"}, ir_req, (m_phase == 1));
    check({tag, ".in_service"}, in_service, (m_phase == 2));
    check({tag, ".ir_id"}, ir_id, m_id);
    check({tag, ".pending"}, pending, m_pend);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model(tag);
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic cfg_write(input logic sel, input logic [N-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
    cycle("cfg");
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic pulse_ack();
    ir_ack = 1'b1; cycle("ack"); ir_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; cycle("eret"); eret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_src = '1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_wdata = '0;
    glb_en = 1'b0; ir_ack = 1'b0; eret = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.ir_req", ir_req, 0);
    check("rst.ir_id", ir_id, 0);
    check("rst.pending", pending, 0);
    check("rst.in_service", in_service, 0);

    // Lines high but everything masked: pending fills, no request.
    rst_n  = 1'b1;
    glb_en = 1'b1;
    cycles(6, "masked");
    check("masked.no_req", ir_req, 0);
    check("masked.pending", pending, 8'hFF);

    // Flush stale pending via level mode, then back to edge and unmask.
    glb_en  = 1'b0;
    irq_src = '0;
    cfg_write(1'b1, 8'h00);
    cycles(4, "flush");
    cfg_write(1'b1, 8'hFF);
    cfg_write(1'b0, 8'hFF);
    check("flush.pending", pending, 0);
    glb_en = 1'b1;
    cycles(2, "idle");

    // Edge on src 5: request visible exactly four edges later.
    irq_src = 8'h20;
    cycles(3, "lat");
    check("lat.early", ir_req, 0);
    cycle("lat");
    check("lat.req", ir_req, 1);
    check("lat.id", ir_id, 5);
    irq_src = '0;
    pulse_ack();
    check("ack5.pending", pending[5], 0);
    check("ack5.in_service", in_service, 1);
    pulse_eret();
    check("eret5.idle", in_service, 0);

    // Simultaneous edges on 6 and 2: 2 first, then 6.
    irq_src = 8'h44;
    cycles(4, "prio");
    check("prio.id2", ir_id, 2);
    irq_src = '0;
    pulse_ack();
    pulse_eret();
    cycle("rearb");
    check("rearb.req", ir_req, 1);
    check("rearb.id6", ir_id, 6);
    pulse_ack();
    pulse_eret();

    // Level-mode src 3 held high re-requests after service.
    cfg_write(1'b1, 8'hF7);
    irq_src = 8'h08;
    cycles(4, "lvl");
    check("lvl.id3", ir_id, 3);
    pulse_ack();
    pulse_eret();
    cycles(2, "lvl2");
    check("lvl2.req", ir_req, 1);
    check("lvl2.id3", ir_id, 3);
    pulse_ack();
    irq_src = '0;
    cycles(2, "lvldrop");
    check("lvldrop.still", pending[3], 1);
    cycle("lvldrop");
    check("lvldrop.clear", pending[3], 0);
    pulse_eret();
    cfg_write(1'b1, 8'hFF);

    // glb_en drop in REQ withdraws the request, keeps pending.
    irq_src = 8'h01;
    cycles(4, "glb");
    check("glb.req", ir_req, 1);
    glb_en = 1'b0;
    cycle("glb_off");
    check("glb_off.req", ir_req, 0);
    check("glb_off.pend0", pending[0], 1);
    glb_en = 1'b1;
    cycles(2, "glb_on");
    check("glb_on.req", ir_req, 1);
    check("glb_on.id0", ir_id, 0);
    irq_src = '0;
    pulse_ack();
    pulse_eret();

    // Edge on src 1 while servicing src 4 waits for eret.
    irq_src = 8'h10;
    cycles(4, "svc");
    check("svc.id4", ir_id, 4);
    pulse_ack();
    irq_src = 8'h02;
    cycles(5, "svc_hold");
    check("svc_hold.noreq", ir_req, 0);
    check("svc_hold.pend1", pending[1], 1);
    pulse_eret();
    cycle("svc_next");
    check("svc_next.id1", ir_id, 1);
    pulse_ack();

    // Asynchronous reset mid-service.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.in_service", in_service, 0);
    check("arst.ir_req", ir_req, 0);
    check("arst.pending", pending, 0);
    check("arst.ir_id", ir_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    irq_src = '0;
    cfg_write(1'b0, 8'hFF);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) irq_src[i] = ~irq_src[i];
      glb_en  = ($urandom_range(0, 9) != 0);
      ir_ack  = ($urandom_range(0, 3) == 0);
      eret    = ($urandom_range(0, 3) == 0);
      cfg_we  = ($urandom_range(0, 15) == 0);
      cfg_sel = 1'($urandom_range(0, 1));
      cfg_wdata = N'($urandom);
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
